operand_collector: RTL and testbench

//  Upstream front-end for the q = ((a-b)*(3c+1) - 4d) >>> 1 arithmetic pipeline.

---
 rtl/operand_collector.sv | 152 +++++++++++++++
 tb/tb_operand_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// Operand collector: gathers a, b, c, d from independent valid/ready handshakes
// and issues them as one aligned set for one cycle. Stale partial sets are dropped
// after a programmable idle timeout and counted in a saturating counter.
module operand_collector #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  artsn_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [DATA_WIDTH-1:0] c_i,
  input  logic                  c_valid_i,
  output logic                  c_ready_o,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic                  d_valid_i,
  output logic                  d_ready_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic                  a_valid_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  b_valid_o,
  output logic [DATA_WIDTH-1:0] c_o,
  output logic                  c_valid_o,
  output logic [DATA_WIDTH-1:0] d_o,
  output logic                  d_valid_o,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

  // A zero timeout would give a zero-width timer; keep one bit so the logic stays legal.
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TimerW-1:0] TimerLast =
      TimerW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic {StCollect, StIssue} state_e;

  state_e                         state_q, state_d;
  logic [3:0]                     full_q, full_d;
  logic [3:0][DATA_WIDTH-1:0]     data_q;
  logic [3:0][DATA_WIDTH-1:0]     din;
  logic [3:0]                     vin;
  logic [3:0]                     ready;
  logic [3:0]                     cap;
  logic [TimerW-1:0]              timer_q, timer_d;
  logic                           timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic                           live_q;
  logic                           issue;

  // Slot index 3..0 corresponds to operand a..d.
  assign din = {a_i, b_i, c_i, d_i};
  assign vin = {a_valid_i, b_valid_i, c_valid_i, d_valid_i};

  // live_q keeps every ready low until the first edge after reset release.
  assign ready = (live_q && (state_q == StCollect)) ? ~full_q : 4'b0000;
  assign cap   = vin & ready;
  assign issue = (state_q == StIssue);

  assign a_ready_o  = ready[3];
  assign b_ready_o  = ready[2];
  assign c_ready_o  = ready[1];
  assign d_ready_o  = ready[0];
  assign a_o        = data_q[3];
  assign b_o        = data_q[2];
  assign c_o        = data_q[1];
  assign d_o        = data_q[0];
  // All strobes come straight from the single state flop so they can never skew.
  assign a_valid_o  = issue;
  assign b_valid_o  = issue;
  assign c_valid_o  = issue;
  assign d_valid_o  = issue;
  assign timeout_o  = timeout_q;
  assign drop_cnt_o = cnt_q;

  // Next-state: slot fill, issue handoff, idle timer and drop accounting.
  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      StCollect: begin
        full_d = full_q | cap;
        if (&full_d) begin
          state_d = StIssue;
          timer_d = '0;
        end else if ((|cap) || (full_d == 4'b0000)) begin
          // Any capture restarts the idle window; an empty collector never times out.
          timer_d = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (timer_q == TimerLast) begin
            full_d    = 4'b0000;
            timer_d   = '0;
            timeout_d = 1'b1;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StIssue: begin
        full_d  = 4'b0000;
        timer_d = '0;
        state_d = StCollect;
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      state_q   <= StCollect;
      full_q    <= 4'b0000;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      live_q    <= 1'b1;
    end
  end

  // Slot data registers load only on an accepted handshake and otherwise hold.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap[i]) begin
          data_q[i] <= din[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: directed scenarios plus randomized offers, all
// checked every cycle against a behavioural model of the collection rules.
module tb_operand_collector;

  localparam int DW  = 16;
  localparam int TO  = 4;
  localparam int CW  = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic artsn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]         vin;
  logic [3:0][DW-1:0] xin;
  logic a_ready, b_ready, c_ready, d_ready;
  logic a_valid, b_valid, c_valid, d_valid;
  logic [DW-1:0] a_out, b_out, c_out, d_out;
  logic timeout;
  logic [CW-1:0] drop_cnt;

  operand_collector #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i     (clk),
    .artsn_i   (artsn),
    .a_i       (xin[3]),
    .a_valid_i (vin[3]),
    .a_ready_o (a_ready),
    .b_i       (xin[2]),
    .b_valid_i (vin[2]),
    .b_ready_o (b_ready),
    .c_i       (xin[1]),
    .c_valid_i (vin[1]),
    .c_ready_o (c_ready),
    .d_i       (xin[0]),
    .d_valid_i (vin[0]),
    .d_ready_o (d_ready),
    .a_o       (a_out),
    .a_valid_o (a_valid),
    .b_o       (b_out),
    .b_valid_o (b_valid),
    .c_o       (c_out),
    .c_valid_o (c_valid),
    .d_o       (d_out),
    .d_valid_o (d_valid),
    .timeout_o (timeout),
    .drop_cnt_o(drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Behavioural model: which operands are held, their values, whether a set is
  // being presented, how long the partial set has been idle, and drop bookkeeping.
  bit                 m_live;
  bit                 m_issue;
  bit                 m_to;
  bit [3:0]           m_held;
  logic [3:0][DW-1:0] m_val;
  int                 m_idle;
  int                 m_drops;

  function automatic void model_reset();
    m_live  = 0;
    m_issue = 0;
    m_to    = 0;
    m_held  = '0;
    m_val   = '0;
    m_idle  = 0;
    m_drops = 0;
  endfunction

  function automatic bit [3:0] model_ready();
    return (m_live && !m_issue) ? ~m_held : 4'b0000;
  endfunction

  // Advance the model by one clock edge given this cycle's offers.
  function automatic void model_edge(input logic [3:0] v, input logic [3:0][DW-1:0] x);
    bit [3:0] take;
    take = v & model_ready();
    m_to = 0;
    if (m_issue) begin
      m_issue = 0;
      m_held  = '0;
      m_idle  = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (take[i]) begin
          m_held[i] = 1;
          m_val[i]  = x[i];
        end
      end
      if (m_held == 4'hf) begin
        m_issue = 1;
        m_idle  = 0;
      end else if (take != 0 || m_held == 0) begin
        m_idle = 0;
      end else if (m_idle + 1 == TO) begin
        m_held  = '0;
        m_idle  = 0;
        m_to    = 1;
        m_drops = (m_drops < CNT_MAX) ? m_drops + 1 : CNT_MAX;
      end else begin
        m_idle++;
      end
    end
    m_live = 1;
  endfunction

  task automatic check_outputs();
    check("ready", {a_ready, b_ready, c_ready, d_ready}, 64'(model_ready()));
    check("valid", {a_valid, b_valid, c_valid, d_valid}, m_issue ? 64'hf : 64'h0);
    check("data", {a_out, b_out, c_out, d_out}, 64'(m_val));
    check("timeout", 64'(timeout), 64'(m_to));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic cyc(input logic [3:0] v, input logic [3:0][DW-1:0] x);
    check_outputs();
    vin = v;
    xin = x;
    model_edge(v, x);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(4'b0000, {4{16'($urandom)}});
    end
  endtask

  // Reset held for two cycles; the release cycle still shows readies low.
  task automatic do_reset();
    artsn = 1'b0;
    vin   = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    artsn = 1'b1;
    check_outputs();
    model_edge(4'b0000, '0);
    @(negedge clk);
  endtask

  initial begin
    vin = '0;
    xin = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Same-cycle set.
    cyc(4'b1111, {16'd5, 16'd2, 16'd1, 16'd3});
    check("t1_issue_valid", 64'(a_valid & b_valid & c_valid & d_valid), 64'd1);
    check("t1_issue_data", {a_out, b_out, c_out, d_out}, {16'd5, 16'd2, 16'd1, 16'd3});
    idle(1);
    check("t1_ready_back", {a_ready, b_ready, c_ready, d_ready}, 64'hf);
    idle(2);

    // Staggered set with an ignored second offer on a.
    do_reset();
    cyc(4'b1000, {16'd7, 16'd0, 16'd0, 16'd0});
    check("t2_a_ready_low", 64'(a_ready), 64'd0);
    cyc(4'b1000, {16'd99, 16'd0, 16'd0, 16'd0});
    cyc(4'b0100, {16'd0, 16'hfffc, 16'd0, 16'd0});
    cyc(4'b0010, {16'd0, 16'd0, 16'd2, 16'd0});
    idle(1);
    cyc(4'b0001, {16'd0, 16'd0, 16'd0, 16'd1});
    check("t2_issue", {a_valid, a_out, b_out, c_out, d_out},
          {1'b1, 16'd7, 16'hfffc, 16'd2, 16'd1});
    idle(2);

    // Timeout drops a partial set; the next set carries only new values.
    do_reset();
    cyc(4'b1100, {16'd11, 16'd12, 16'd0, 16'd0});
    idle(4);
    check("t3_timeout", {timeout, 2'(drop_cnt), a_ready, b_ready, c_ready, d_ready},
          {1'b1, 2'd1, 4'hf});
    cyc(4'b1111, {16'd21, 16'd22, 16'd23, 16'd24});
    check("t3_new_set", {a_valid, a_out, b_out, c_out, d_out},
          {1'b1, 16'd21, 16'd22, 16'd23, 16'd24});
    idle(2);

    // Capture in the expiry cycle wins over the drop.
    do_reset();
    cyc(4'b1000, {16'd1, 16'd0, 16'd0, 16'd0});
    idle(3);
    cyc(4'b0010, {16'd0, 16'd0, 16'd3, 16'd0});
    check("t4_no_timeout", {timeout, 2'(drop_cnt)}, 64'd0);
    idle(3);
    cyc(4'b0101, {16'd0, 16'd2, 16'd0, 16'd4});
    check("t4_issue", {a_valid, timeout, a_out, b_out, c_out, d_out},
          {1'b1, 1'b0, 16'd1, 16'd2, 16'd3, 16'd4});
    idle(2);

    // Reset mid-collect loses the partial set silently.
    cyc(4'b1110, {16'd8, 16'd9, 16'd10, 16'd0});
    do_reset();
    cyc(4'b0001, {16'd0, 16'd0, 16'd0, 16'd5});
    idle(2);
    check("t5_no_issue", {a_valid, timeout, 2'(drop_cnt)}, 64'd0);
    idle(4);

    // Drop counter saturates.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1000, {16'(k), 16'd0, 16'd0, 16'd0});
      idle(4);
      check("t6_pulse", 64'(timeout), 64'd1);
      check("t6_cnt", 64'(drop_cnt), 64'((k + 1 > CNT_MAX) ? CNT_MAX : k + 1));
    end
    idle(2);

    // Randomized offers with varying density and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      int den;
      logic [3:0] v;
      den = 1 + (n / 500);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, den) == 0);
        cyc(v, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      end
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
